mips_mem_responder: RTL and testbench



---
 rtl/mips_mem_responder_pkg.sv | 16 +
 rtl/mips_mem_responder_word_ram.sv | 38 +++
 rtl/mips_mem_responder.sv | 137 +++++++++++++
 tb/tb_mips_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_responder_pkg.sv
// Shared memory-space constants and FSM state encodings for the MIPS memory responder.
package mips_mem_responder_pkg;

   // Byte address at which the responder's local data window starts.
   localparam logic [31:0] D_START_ADDRESS = 32'h1001_0000;

   // Width of the wait-state down-counter (WAIT_STATES is 0..15).
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mips_mem_responder_word_ram.sv
// Single-port word RAM: synchronous write, synchronous read into a resettable
// output register that can also be cleared (used to zero data on errors).
module mips_mem_responder_word_ram #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          rd_en,
   input  logic          rd_clr,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Read register: loads on rd_en, zeroes on rd_clr, otherwise holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (rd_clr) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: accepts one word request,
// decodes it against a fixed window, models latency, then commits or returns data.
module mips_mem_responder
   import mips_mem_responder_pkg::*;
#(
   parameter int unsigned   N           = 32,
   parameter int unsigned   DEPTH_WORDS = 256,
   parameter logic [N-1:0]  BASE_ADDR   = N'(D_START_ADDRESS),
   parameter int unsigned   WAIT_STATES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   input  logic         req_we,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         req_ready,
   output logic         rsp_valid,
   output logic [N-1:0] rsp_rdata,
   output logic         rsp_err
);

   localparam int unsigned  AW        = $clog2(DEPTH_WORDS);
   localparam logic [N-1:0] WIN_BYTES = N'(4 * DEPTH_WORDS);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             we_q;
   logic             err_q;
   logic [AW-1:0]    idx_q;
   logic [N-1:0]     wdata_q;

   logic [N-1:0]     offset_c;
   logic             err_c;
   logic [AW-1:0]    idx_c;
   logic             resp_entry_c;
   logic             cur_we_c;
   logic             cur_err_c;
   logic [AW-1:0]    ram_addr_c;
   logic [N-1:0]     ram_wdata_c;
   logic             ram_we_c;
   logic             ram_rd_en_c;
   logic             ram_rd_clr_c;

   // Address decode of the presented request; below-base addresses wrap high.
   always_comb begin
      offset_c = req_addr - BASE_ADDR;
      err_c    = (req_addr[1:0] != 2'b00) || (offset_c >= WIN_BYTES);
      idx_c    = offset_c[AW+1:2];
   end

   // RAM controls: act on the edge that enters RESP. With no wait states that
   // edge is the acceptance edge, so the live request fields are used in IDLE.
   always_comb begin
      resp_entry_c = ((state == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                     ((state == ST_WAIT) && (cnt == '0));
      cur_we_c     = (state == ST_IDLE) ? req_we    : we_q;
      cur_err_c    = (state == ST_IDLE) ? err_c     : err_q;
      ram_addr_c   = (state == ST_IDLE) ? idx_c     : idx_q;
      ram_wdata_c  = (state == ST_IDLE) ? req_wdata : wdata_q;
      ram_we_c     = resp_entry_c && !cur_err_c &&  cur_we_c;
      ram_rd_en_c  = resp_entry_c && !cur_err_c && !cur_we_c;
      ram_rd_clr_c = resp_entry_c &&  cur_err_c;
   end

   // Request FSM with wait-state counter and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  err_q     <= err_c;
                  idx_q     <= idx_c;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= err_c;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_W'(WAIT_STATES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err_q;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   mips_mem_responder_word_ram #(
      .W     (N),
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_word_ram (
      .clk    (clk),
      .rst    (rst),
      .we     (ram_we_c),
      .rd_en  (ram_rd_en_c),
      .rd_clr (ram_rd_clr_c),
      .addr   (ram_addr_c),
      .wdata  (ram_wdata_c),
      .rdata  (rsp_rdata)
   );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: one instance with one wait state, one with none,
// driven by directed and random requests and checked against a word-map model.
module tb_mips_mem_responder;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam logic [31:0] WIN  = 32'd1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, rst1;
   logic        vld_in0, we_in0, vld_in1, we_in1;
   logic [31:0] addr_in0, wd_in0, addr_in1, wd_in1;
   logic        rdy0, rsp_v0, rsp_e0, rdy1, rsp_v1, rsp_e1;
   logic [31:0] rsp_d0, rsp_d1;

   mips_mem_responder #(.N(32), .DEPTH_WORDS(256), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst0), .req_valid(vld_in0), .req_we(we_in0), .req_addr(addr_in0),
      .req_wdata(wd_in0), .req_ready(rdy0), .rsp_valid(rsp_v0), .rsp_rdata(rsp_d0), .rsp_err(rsp_e0));

   mips_mem_responder #(.N(32), .DEPTH_WORDS(256), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut1 (
      .clk(clk), .rst(rst1), .req_valid(vld_in1), .req_we(we_in1), .req_addr(addr_in1),
      .req_wdata(wd_in1), .req_ready(rdy1), .rsp_valid(rsp_v1), .rsp_rdata(rsp_d1), .rsp_err(rsp_e1));

   int errors = 0;
   int checks = 0;

   // Reference model: per-instance word maps plus last returned read data.
   logic [31:0] mem0 [int];
   logic [31:0] mem1 [int];
   logic [31:0] last_rd [2];
   bit          last_ok [2];
   time         last_acc_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic get_rdy(input int sel);
      return (sel == 1) ? rdy1 : rdy0;
   endfunction
   function automatic logic get_vld(input int sel);
      return (sel == 1) ? rsp_v1 : rsp_v0;
   endfunction
   function automatic logic get_err(input int sel);
      return (sel == 1) ? rsp_e1 : rsp_e0;
   endfunction
   function automatic logic [31:0] get_rd(input int sel);
      return (sel == 1) ? rsp_d1 : rsp_d0;
   endfunction

   task automatic set_in(input int sel, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
      if (sel == 1) begin
         vld_in1 = v; we_in1 = we; addr_in1 = a; wd_in1 = d;
      end else begin
         vld_in0 = v; we_in0 = we; addr_in0 = a; wd_in0 = d;
      end
   endtask

   function automatic bit addr_bad(input logic [31:0] a);
      logic [31:0] off;
      logic [1:0]  lo;
      off = a - BASE;
      lo  = a[1:0];
      return (lo != 2'b00) || (off >= WIN);
   endfunction

   // Apply a completed request to the model and return the expected response.
   task automatic apply_model(input int sel, input logic we, input logic [31:0] a,
                              input logic [31:0] d, output bit e,
                              output logic [31:0] exp, output bit known);
      int idx;
      e   = addr_bad(a);
      idx = int'((a - BASE) >> 2);
      if (e) begin
         exp = 32'h0; known = 1'b1;
      end else if (we) begin
         if (sel == 1) mem1[idx] = d; else mem0[idx] = d;
         exp = last_rd[sel]; known = last_ok[sel];
      end else if (sel == 1 && mem1.exists(idx)) begin
         exp = mem1[idx]; known = 1'b1;
      end else if (sel == 0 && mem0.exists(idx)) begin
         exp = mem0[idx]; known = 1'b1;
      end else begin
         exp = 32'h0; known = 1'b0;
      end
      last_rd[sel] = exp;
      last_ok[sel] = known;
   endtask

   // Present a request at a falling edge and return on its acceptance edge.
   task automatic accept(input int sel, input logic we, input logic [31:0] a, input logic [31:0] d);
      int waits = 0;
      set_in(sel, 1'b1, we, a, d);
      while (!get_rdy(sel) && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      check("accept_ready", 32'(get_rdy(sel)), 32'd1);
      @(posedge clk);
      last_acc_t = $time;
   endtask

   // Full request: acceptance, scrambled inputs while in flight, timing and data checks.
   task automatic do_req(input int sel, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
      int ws;
      bit e, known;
      logic [31:0] exp;
      ws = (sel == 1) ? 1 : 0;
      accept(sel, we, a, d);
      apply_model(sel, we, a, d, e, exp, known);
      @(negedge clk);
      set_in(sel, hold, 1'($urandom), $urandom, $urandom);
      for (int c = 1; c <= ws; c++) begin
         check("wait_ready", 32'(get_rdy(sel)), 32'd0);
         check("wait_valid", 32'(get_vld(sel)), 32'd0);
         @(negedge clk);
      end
      check("rsp_valid", 32'(get_vld(sel)), 32'd1);
      check("rsp_ready", 32'(get_rdy(sel)), 32'd0);
      check("rsp_err", 32'(get_err(sel)), 32'(e));
      if (known) check("rsp_rdata", get_rd(sel), exp);
      @(negedge clk);
      check("idle_ready", 32'(get_rdy(sel)), 32'd1);
      check("idle_valid", 32'(get_vld(sel)), 32'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 6) return BASE + 32'(4 * $urandom_range(0, 15));
      if (r == 7) return BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      if (r == 8) return BASE + WIN + 32'(4 * $urandom_range(0, 3));
      return BASE - 32'(4 * $urandom_range(1, 4));
   endfunction

   initial begin
      time t_prev;
      bit seen;
      rst0 = 1'b1; rst1 = 1'b1;
      set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int s = 0; s < 2; s++) begin
         last_rd[s] = 32'h0; last_ok[s] = 1'b1;
      end
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         check("reset_ready", 32'(get_rdy(s)), 32'd1);
         check("reset_valid", 32'(get_vld(s)), 32'd0);
         check("reset_err",   32'(get_err(s)), 32'd0);
         check("reset_rdata", get_rd(s), 32'h0);
      end
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);

      // Directed: write/readback, misaligned, out-of-window, wrap below base, top word.
      do_req(1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
      do_req(1, 1'b0, BASE + 32'h10, 32'h0, 1'b0);
      do_req(1, 1'b1, BASE, 32'hA5A5_0000, 1'b0);
      do_req(1, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 1'b0);
      do_req(1, 1'b0, BASE, 32'h0, 1'b0);
      do_req(1, 1'b0, BASE + WIN, 32'h0, 1'b0);
      do_req(1, 1'b0, BASE - 32'h4, 32'h0, 1'b0);
      do_req(1, 1'b1, BASE + WIN - 32'h4, 32'h0BAD_C0DE, 1'b0);
      do_req(1, 1'b0, BASE + WIN - 32'h4, 32'h0, 1'b0);

      // Reset while in WAIT: request dropped, no response, write not committed.
      accept(1, 1'b1, BASE, 32'h1234_5678);
      @(negedge clk);
      set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
      rst1 = 1'b1;
      #1;
      check("rst_wait_ready", 32'(rdy1), 32'd1);
      check("rst_wait_valid", 32'(rsp_v1), 32'd0);
      @(negedge clk);
      rst1 = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_v1) seen = 1'b1;
      end
      check("rst_wait_no_rsp", 32'(seen), 32'd0);
      last_rd[1] = 32'h0; last_ok[1] = 1'b1;
      do_req(1, 1'b0, BASE, 32'h0, 1'b0);

      // Reset during RESP: strobe drops at once, committed write persists.
      begin
         bit e, known;
         logic [31:0] exp;
         accept(1, 1'b1, BASE + 32'h8, 32'hCAFE_F00D);
         apply_model(1, 1'b1, BASE + 32'h8, 32'hCAFE_F00D, e, exp, known);
         @(negedge clk);
         set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         check("rst_resp_pre_valid", 32'(rsp_v1), 32'd1);
         rst1 = 1'b1;
         #1;
         check("rst_resp_valid", 32'(rsp_v1), 32'd0);
         @(negedge clk);
         rst1 = 1'b0;
         last_rd[1] = 32'h0; last_ok[1] = 1'b1;
         @(negedge clk);
      end
      do_req(1, 1'b0, BASE + 32'h8, 32'h0, 1'b0);

      // Zero wait states: seed data then back-to-back reads with req_valid held.
      for (int i = 0; i < 4; i++)
         do_req(0, 1'b1, BASE + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0);
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         do_req(0, 1'b0, BASE + 32'(4 * i), 32'h0, 1'b1);
         if (i > 0) check("b2b_period", 32'(last_acc_t - t_prev), 32'd20);
         t_prev = last_acc_t;
      end
      set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Randomised traffic on both instances.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 40; i++)
            do_req(s, 1'($urandom), rand_addr(), $urandom, 1'($urandom));
         set_in(s, 1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
